// File: rtl/qif_pkg.sv
// Shared types and default parameters for quad_input_filter.
package qif_pkg;
  typedef enum logic {STABLE = 1'b0, CAND = 1'b1} filt_state_e;

  localparam int QIF_SYNC_STAGES_DEF = 2;
  localparam int QIF_FILT_W_DEF      = 8;
  localparam int QIF_GCNT_W_DEF      = 16;
endpackage

// File: rtl/quad_input_filter_if.sv
// Encoder pin bundle: raw pins in, filtered levels and step error out.
// Z_raw/Z exist only when QIF_INDEX_EN is defined.
interface quad_input_filter_if;
  logic A_raw;
  logic B_raw;
  logic A;
  logic B;
  logic step_err;
`ifdef QIF_INDEX_EN
  logic Z_raw;
  logic Z;

  modport slave  (input A_raw, B_raw, Z_raw, output A, B, Z, step_err);
  modport master (output A_raw, B_raw, Z_raw, input A, B, Z, step_err);
`else
  modport slave  (input A_raw, B_raw, output A, B, step_err);
  modport master (output A_raw, B_raw, input A, B, step_err);
`endif
endinterface

// File: rtl/qif_channel.sv
// One input channel: synchroniser chain, two-state stability filter and
// run-length counter. toggle/glitch are same-cycle strobes for the top level.
module qif_channel
  import qif_pkg::*;
#(
  parameter int SYNC_STAGES = QIF_SYNC_STAGES_DEF,
  parameter int FILT_W      = QIF_FILT_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              raw,
  input  logic [FILT_W-1:0] eff_len,
  output logic              out,
  output logic              toggle,
  output logic              glitch
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  filt_state_e            state, state_d;
  logic [FILT_W-1:0]      cnt, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      state  <= STABLE;
      cnt    <= '0;
      out    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      state  <= state_d;
      cnt    <= cnt_d;
      out    <= out ^ toggle;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    toggle  = 1'b0;
    glitch  = 1'b0;
    case (state)
      STABLE: begin
        cnt_d = '0;
        if (s != out) begin
          state_d = CAND;
          cnt_d   = FILT_W'(1);
        end
      end
      CAND: begin
        if (s == out) begin
          state_d = STABLE;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt >= eff_len) begin
          // Also catches a FILT_LEN drop below an already-running count.
          state_d = STABLE;
          cnt_d   = '0;
          toggle  = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + FILT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end
endmodule

// File: rtl/quad_input_filter.sv
// Glitch filter in front of the quadrature decoder: per-channel filtering,
// simultaneous-toggle detection and a saturating glitch counter.
// Define QIF_INDEX_EN to add the Z index channel.
module quad_input_filter
  import qif_pkg::*;
#(
  parameter int SYNC_STAGES = QIF_SYNC_STAGES_DEF,
  parameter int FILT_W      = QIF_FILT_W_DEF,
  parameter int GCNT_W      = QIF_GCNT_W_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  quad_input_filter_if.slave  pins,
  input  logic [FILT_W-1:0]   FILT_LEN,
  input  logic                clr_cnt,
  output logic [GCNT_W-1:0]   glitch_cnt
);
`ifdef QIF_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  logic [NCH-1:0]    raw_v, out_v, tog_v, glitch_v;
  logic [FILT_W-1:0] eff_len;
  logic [1:0]        n_glitch;
  logic [GCNT_W:0]   cnt_sum;

  assign eff_len = (FILT_LEN == '0) ? FILT_W'(1) : FILT_LEN;

`ifdef QIF_INDEX_EN
  assign raw_v  = {pins.Z_raw, pins.B_raw, pins.A_raw};
  assign pins.Z = out_v[2];
`else
  assign raw_v  = {pins.B_raw, pins.A_raw};
`endif
  assign pins.A = out_v[0];
  assign pins.B = out_v[1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    qif_channel #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_ch (
      .CLK     (CLK),
      .reset   (reset),
      .raw     (raw_v[i]),
      .eff_len (eff_len),
      .out     (out_v[i]),
      .toggle  (tog_v[i]),
      .glitch  (glitch_v[i])
    );
  end

  always_comb begin
    n_glitch = '0;
    for (int i = 0; i < NCH; i++) n_glitch = n_glitch + 2'(glitch_v[i]);
  end

  assign cnt_sum = {1'b0, glitch_cnt} + (GCNT_W+1)'(n_glitch);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      glitch_cnt    <= '0;
      pins.step_err <= 1'b0;
    end else begin
      pins.step_err <= tog_v[0] & tog_v[1];
      if (clr_cnt)              glitch_cnt <= '0;
      else if (cnt_sum[GCNT_W]) glitch_cnt <= '1;
      else                      glitch_cnt <= cnt_sum[GCNT_W-1:0];
    end
  end
endmodule
